// File: rtl/tdm_deinterleaver.sv
// TDM deinterleaver: collects NUM_CH slot words per frame (slot 0 marked by SOF)
// and presents each complete frame in parallel, tracking lock and framing errors.
module tdm_deinterleaver #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         din_valid,
    input  logic                         din_sof,
    output logic [NUM_CH*DATA_WIDTH-1:0] dout,
    output logic                         dout_valid,
    output logic                         locked,
    output logic                         frame_err,
    output logic [ERR_WIDTH-1:0]         err_count
);

    // Stream handshake: valid-only, no backpressure. A beat is transferred on every
    // rising edge where din_valid=1; din and din_sof are don't-care otherwise.
    // dout_valid and frame_err are single-cycle pulses; dout holds until the next frame.

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_CH - 1);
    localparam logic [CW-1:0] SLOT_ONE  = CW'(1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  slot_q, slot_d;
    logic [DATA_WIDTH-1:0]          buf_q [NUM_CH];
    logic [DATA_WIDTH-1:0]          buf_d [NUM_CH];
    logic [NUM_CH*DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                           dout_valid_q, dout_valid_d;
    logic                           frame_err_q, frame_err_d;
    logic [ERR_WIDTH-1:0]           err_cnt_q, err_cnt_d;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        buf_d        = buf_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (din_sof) begin
                        buf_d[0] = din;
                        slot_d   = SLOT_ONE;
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (din_sof) begin
                        // SOF away from slot 0 resyncs onto the new frame.
                        if (slot_q != '0) begin
                            frame_err_d = 1'b1;
                        end
                        buf_d[0] = din;
                        slot_d   = SLOT_ONE;
                    end else if (slot_q == '0) begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end else begin
                        buf_d[slot_q] = din;
                        if (slot_q == LAST_SLOT) begin
                            slot_d       = '0;
                            dout_valid_d = 1'b1;
                            for (int k = 0; k < NUM_CH; k++) begin
                                dout_d[k*DATA_WIDTH +: DATA_WIDTH] = buf_d[k];
                            end
                        end else begin
                            slot_d = slot_q + 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
            for (int k = 0; k < NUM_CH; k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign locked     = (state_q == LOCKED);
    assign frame_err  = frame_err_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_tdm_deinterleaver.sv
// Directed bench for tdm_deinterleaver (DATA_WIDTH=8, NUM_CH=2, ERR_WIDTH=8).
module tb_tdm_deinterleaver;

  logic        clk;
  logic        rst;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_sof;
  logic [15:0] dout;
  logic        dout_valid;
  logic        locked;
  logic        frame_err;
  logic [7:0]  err_count;

  int errors;
  int checks;

  tdm_deinterleaver #(
    .DATA_WIDTH(8),
    .NUM_CH(2),
    .ERR_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_sof   (din_sof),
    .dout      (dout),
    .dout_valid(dout_valid),
    .locked    (locked),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs change on the falling edge, outputs sampled 1 after the rising edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic s);
    @(negedge clk);
    rst       = r;
    din_valid = v;
    din       = d;
    din_sof   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    // rst must win over an active SOF beat
    step(1'b1, 1'b1, 8'hA5, 1'b1);
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    checks++;
    if ({dout, dout_valid, locked, frame_err, err_count} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: dout=%h dv=%b lk=%b fe=%b ec=%0d, want all 0",
               dout, dout_valid, locked, frame_err, err_count);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (locked !== 1'b0 || dout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release: locked=%b dout=%h, want 0/0000", locked, dout);
    end
  endtask

  task automatic test_basic();
    step(1'b0, 1'b1, 8'h11, 1'b1);
    checks++;
    if (locked !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_sof: locked=%b dv=%b, want 1/0", locked, dout_valid);
    end
    step(1'b0, 1'b1, 8'h22, 1'b0);
    checks++;
    if (dout !== 16'h2211 || dout_valid !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL basic_frame: dout=%h dv=%b lk=%b, want 2211/1/1", dout, dout_valid, locked);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (dout_valid !== 1'b0 || dout !== 16'h2211) begin
      errors++;
      $display("FAIL basic_pulse: dv=%b dout=%h, want 0/2211", dout_valid, dout);
    end
  endtask

  task automatic test_hunt();
    logic [7:0] d_seq [4];
    logic       s_seq [4];
    int         fe_seen;
    int         dv_seen;
    d_seq = '{8'hAA, 8'hBB, 8'h01, 8'h02};
    s_seq = '{1'b0, 1'b0, 1'b1, 1'b0};
    fe_seen = 0;
    dv_seen = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, d_seq[i], s_seq[i]);
      if (frame_err === 1'b1) fe_seen++;
      if (dout_valid === 1'b1) dv_seen++;
      if (i == 1) begin
        checks++;
        if (locked !== 1'b0 || dout !== 16'h0000) begin
          errors++;
          $display("FAIL hunt_discard: locked=%b dout=%h, want 0/0000", locked, dout);
        end
      end
    end
    checks++;
    if (dout !== 16'h0201 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL hunt_frame: dout=%h dv=%b, want 0201/1", dout, dout_valid);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    if (frame_err === 1'b1) fe_seen++;
    if (dout_valid === 1'b1) dv_seen++;
    checks++;
    if (fe_seen !== 0 || err_count !== 8'd0 || dv_seen !== 1) begin
      errors++;
      $display("FAIL hunt_errs: fe_pulses=%0d ec=%0d dv_pulses=%0d, want 0/0/1",
               fe_seen, err_count, dv_seen);
    end
  endtask

  task automatic test_gaps();
    step(1'b0, 1'b1, 8'h33, 1'b1);
    // idle beats carry junk data and a stray SOF, both must be ignored
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'hE0 + 8'(i), 1'b1);
      checks++;
      if (dout !== 16'h0201 || dout_valid !== 1'b0 || frame_err !== 1'b0) begin
        errors++;
        $display("FAIL gaps_idle%0d: dout=%h dv=%b fe=%b, want 0201/0/0",
                 i, dout, dout_valid, frame_err);
      end
    end
    step(1'b0, 1'b1, 8'h44, 1'b0);
    checks++;
    if (dout !== 16'h4433 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL gaps_frame: dout=%h dv=%b, want 4433/1", dout, dout_valid);
    end
  endtask

  task automatic test_early_sof();
    step(1'b0, 1'b1, 8'h55, 1'b1);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL early_first: fe=%b, want 0", frame_err);
    end
    step(1'b0, 1'b1, 8'h66, 1'b1);
    checks++;
    if (frame_err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_err: fe=%b ec=%0d lk=%b dv=%b, want 1/1/1/0",
               frame_err, err_count, locked, dout_valid);
    end
    step(1'b0, 1'b1, 8'h77, 1'b0);
    checks++;
    if (dout !== 16'h7766 || dout_valid !== 1'b1 || frame_err !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL early_frame: dout=%h dv=%b fe=%b lk=%b, want 7766/1/0/1",
               dout, dout_valid, frame_err, locked);
    end
  endtask

  task automatic test_missing_sof();
    step(1'b0, 1'b1, 8'h99, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd2 || dout !== 16'h7766) begin
      errors++;
      $display("FAIL missing_err: fe=%b lk=%b ec=%0d dout=%h, want 1/0/2/7766",
               frame_err, locked, err_count, dout);
    end
    step(1'b0, 1'b1, 8'h01, 1'b1);
    step(1'b0, 1'b1, 8'h02, 1'b0);
    checks++;
    if (dout !== 16'h0201 || dout_valid !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL missing_recover: dout=%h dv=%b lk=%b, want 0201/1/1", dout, dout_valid, locked);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b0, 1'b1, 8'h10, 1'b1);
    step(1'b1, 1'b1, 8'h20, 1'b0);
    checks++;
    if ({dout, dout_valid, locked, frame_err, err_count} !== 27'd0) begin
      errors++;
      $display("FAIL midrst_outputs: dout=%h dv=%b lk=%b fe=%b ec=%0d, want all 0",
               dout, dout_valid, locked, frame_err, err_count);
    end
    // partial frame is gone: a non-SOF beat after reset must not complete anything
    step(1'b0, 1'b1, 8'h20, 1'b0);
    checks++;
    if (dout_valid !== 1'b0 || locked !== 1'b0 || frame_err !== 1'b0 || dout !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_hunt: dv=%b lk=%b fe=%b dout=%h, want 0/0/0/0000",
               dout_valid, locked, frame_err, dout);
    end
    step(1'b0, 1'b1, 8'h30, 1'b1);
    step(1'b0, 1'b1, 8'h40, 1'b0);
    checks++;
    if (dout !== 16'h4030 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_frame: dout=%h dv=%b, want 4030/1", dout, dout_valid);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b1);
      step(1'b0, 1'b1, 8'(i + 1), 1'b0);
      step(1'b0, 1'b1, 8'hC3, 1'b0);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      if (i == 253 || i == 299) begin
        checks++;
        if (err_count !== 8'(exp_cnt) || frame_err !== 1'b1) begin
          errors++;
          $display("FAIL sat_count%0d: ec=%0d fe=%b, want %0d/1", i, err_count, frame_err, exp_cnt);
        end
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (err_count !== 8'd255 || frame_err !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL sat_hold: ec=%0d fe=%b lk=%b, want 255/0/0", err_count, frame_err, locked);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    din       = 8'h00;
    din_valid = 1'b0;
    din_sof   = 1'b0;
    test_reset();
    test_basic();
    test_hunt();
    test_gaps();
    test_early_sof();
    test_missing_sof();
    test_mid_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_deinterleaver.md
TDM_DEINTERLEAVER -- requirements
Module: tdm_deinterleaver

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the width of one TDM slot word.
REQ-002 The module SHALL have parameter NUM_CH, default 2, giving the number of slots per TDM frame; the legal range is 2..16.
REQ-003 The module SHALL have parameter ERR_WIDTH, default 8, giving the width of the error counter.
REQ-004 The module SHALL have a single clock; reset is synchronous and active-high.
REQ-005 The module SHALL have port clk, input, 1 bit: the TDM-rate clock; all logic is on the rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port din, input, DATA_WIDTH bits: the TDM slot word.
REQ-008 The module SHALL have port din_valid, input, 1 bit: din is a slot word this cycle.
REQ-009 The module SHALL have port din_sof, input, 1 bit: start-of-frame marker, qualified by din_valid, asserted with slot 0.
REQ-010 The module SHALL have port dout, output, NUM_CH*DATA_WIDTH bits: the deinterleaved frame, with slot k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 The module SHALL have port dout_valid, output, 1 bit: a one-cycle pulse when a new dout frame is presented.
REQ-012 The module SHALL have port locked, output, 1 bit: high while in the LOCKED state.
REQ-013 The module SHALL have port frame_err, output, 1 bit: a one-cycle pulse on any framing violation.
REQ-014 The module SHALL have port err_count, output, ERR_WIDTH bits: a saturating count of framing violations.

Function
REQ-015 The module SHALL implement a two-state FSM with states HUNT and LOCKED, plus a slot counter slot_cnt ranging 0..NUM_CH-1.
REQ-016 The module SHALL maintain a collection buffer (NUM_CH words) separate from the dout register, so that dout is stable between dout_valid pulses.
REQ-017 In HUNT, a beat with din_valid=1 and din_sof=0 SHALL be discarded, with no error flagged.
REQ-018 In HUNT, a beat with din_valid=1 and din_sof=1 SHALL store din to buffer slot 0, set slot_cnt to 1, and transition to LOCKED.
REQ-019 In LOCKED, a beat with din_valid=1 and din_sof=(slot_cnt==0) SHALL store din to buffer slot slot_cnt and increment slot_cnt, wrapping from NUM_CH-1 to 0.
REQ-020 In LOCKED, storing the slot NUM_CH-1 word SHALL cause dout to be loaded with the complete frame (buffer slots 0..NUM_CH-2 plus the current din) and dout_valid to pulse on the next cycle; latency from the last-slot beat to dout_valid is exactly 1 cycle.
REQ-021 A cycle with din_valid=0 SHALL leave the buffer, slot_cnt and state unchanged, so gaps between beats are legal anywhere in a frame.
REQ-022 Early SOF: in LOCKED with din_valid=1, din_sof=1 and slot_cnt!=0, the module SHALL discard the partial frame, pulse frame_err, store din to slot 0, set slot_cnt to 1, and remain in LOCKED (resync).
REQ-023 Missing SOF: in LOCKED with din_valid=1, din_sof=0 and slot_cnt==0, the module SHALL discard the beat, pulse frame_err, and go to HUNT.
REQ-024 frame_err SHALL be registered and assert 1 cycle after the offending beat.
REQ-025 err_count SHALL increment by 1 on each frame_err pulse and hold at 2^ERR_WIDTH-1 (no wrap).
REQ-026 din_sof SHALL be ignored whenever din_valid=0.
REQ-027 locked SHALL equal (state==LOCKED), registered.
REQ-028 Completing a frame and generating an error in the same cycle is impossible, because slot NUM_CH-1 with sof=1 is an early-SOF error and no frame completes; only frame_err pulses in that case.

Reset
REQ-029 While rst=1, the module SHALL set state=HUNT, slot_cnt=0, buffer=0, dout=0, dout_valid=0, locked=0, frame_err=0, err_count=0.
REQ-030 The module SHALL ignore din, din_valid and din_sof in any cycle where rst=1.
REQ-031 A reset asserted mid-frame SHALL discard the partial frame; the first post-reset frame SHALL be accepted only at the next SOF.
REQ-032 dout SHALL retain 0 after reset until the first complete frame.

Verification (DATA_WIDTH=8, NUM_CH=2)
REQ-033 The bench SHALL check basic deinterleave: after reset, beats (0x11,sof=1),(0x22,sof=0) -> 1 cycle after the second beat, dout=0x2211 and dout_valid=1 for one cycle, locked=1.
REQ-034 The bench SHALL check hunt: beats (0xAA,sof=0),(0xBB,sof=0),(0x01,sof=1),(0x02,sof=0) -> the first two are discarded, dout=0x0201 once, frame_err is never asserted, and err_count=0.
REQ-035 The bench SHALL check gaps: the frame 0x33(sof),idle×3,0x44 -> dout=0x4433 one cycle after 0x44, and dout is unchanged during the idle cycles.
REQ-036 The bench SHALL check early SOF: locked, then beats 0x55(sof),0x66(sof),0x77 -> frame_err pulses after 0x66, dout=0x7766, err_count=1, and locked stays 1.
REQ-037 The bench SHALL check missing SOF: locked at slot 0, then beat 0x99(sof=0) -> frame_err pulses, locked=0, and the next frame 0x01(sof),0x02 yields dout=0x0201.
REQ-038 The bench SHALL check mid-frame reset and saturation: rst asserted after 0x10(sof) -> no dout_valid, and all outputs are 0; then 300 missing-SOF errors -> err_count=255.
